voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL provide parameters: N_VOICES, default 8, number of oscillator voices; FREQ_W, default 16, oscillator frequency word width; VEL_W, default 8, velocity width; AGE_W, default 8, per-voice age counter width.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ev_valid  input  1  note event present.
REQ-006 ev_ready  output  1  allocator can accept an event.
REQ-007 ev_on  input  1  1 = note-on, 0 = note-off.
REQ-008 ev_note  input  7  MIDI note number.
REQ-009 ev_freq  input  FREQ_W  oscillator frequency word for note-on.
REQ-010 ev_velocity  input  VEL_W  velocity for note-on.
REQ-011 voice_done  input  N_VOICES  per-voice release-complete pulse from the oscillator envelope.
REQ-012 voice_gate  output  N_VOICES  per-voice gate; 1 = note held.
REQ-013 voice_freq  output  N_VOICES x FREQ_W  per-voice frequency word.
REQ-014 voice_velocity  output  N_VOICES x VEL_W  per-voice velocity.
REQ-015 env_reset  output  N_VOICES  one-cycle pulse that restarts the voice envelope at stage 0.
REQ-016 drop_count  output  8  number of dropped note-ons, saturating at 255.

Function
REQ-017 SHALL keep a per-voice state of FREE, HELD or RELEASING, plus the stored note and age.
REQ-018 Main FSM SHALL be IDLE -> SCAN -> COMMIT -> IDLE; ev_ready = 1 only in IDLE; an event is accepted on a clk edge with ev_valid && ev_ready.
REQ-019 SCAN SHALL examine one voice per cycle, indices 0..N_VOICES-1, taking exactly N_VOICES cycles and tracking: note match, lowest-index FREE voice, and steal candidate.
REQ-020 COMMIT SHALL last 1 cycle; outputs update at the end of COMMIT; event-to-output latency is N_VOICES+2 cycles after acceptance.
REQ-021 Note-on target priority: (1) a HELD or RELEASING voice with equal note is retriggered; (2) the lowest-index FREE voice; (3) the steal candidate per REQ-030; otherwise the event is dropped.
REQ-022 Note-on commit SHALL set the target HELD, set gate=1, load freq, velocity and note, set age=0, and pulse env_reset of the target for exactly 1 cycle.
REQ-023 On every note-on commit, all other non-FREE voices SHALL increment age, saturating at 2^AGE_W-1.
REQ-024 Note-off SHALL move the lowest-index HELD voice with matching note to RELEASING and set gate=0; freq and velocity are held; with no match the event is ignored.
REQ-025 voice_done[i] with voice i RELEASING SHALL set it FREE one cycle later; voice_done on a FREE or HELD voice is ignored.
REQ-026 voice_done pulses arriving in SCAN or COMMIT SHALL be latched in a pending mask and applied on the first IDLE cycle; an intervening retrigger or steal of that voice clears its pending bit.
REQ-027 A dropped note-on SHALL increment drop_count, saturating at 255; voice outputs are unchanged.

Reset
REQ-028 When rst is sampled high, the allocator SHALL enter IDLE; all voices FREE; gate, env_reset, freq, velocity, note, age, pending mask and drop_count = 0; ev_ready = 1 in the first cycle after reset.
REQ-029 rst during SCAN or COMMIT SHALL abort the event with no output change other than the reset values.

Configuration
REQ-030 With VOICE_STEAL_EN defined, when no voice is FREE or matching, the steal candidate SHALL be the RELEASING voice with the largest age; if none is RELEASING, the HELD voice with the largest age; ties go to the lowest index.
REQ-031 Without VOICE_STEAL_EN, the no-candidate case SHALL drop the event per REQ-027, and no steal logic is synthesised.

Structure
REQ-032 The shared package voice_pkg SHALL hold the voice_state_t enum, the alloc_state_t FSM enum, the note_event_t struct (on, note, freq, velocity) and the constant DROP_CNT_MAX = 255.
REQ-033 Per-voice registers (state, note, age, freq, velocity, pending) SHALL live in sub-module voice_slot, instantiated N_VOICES times.

Verification (N_VOICES=4)
REQ-034 After reset, note-on note 60, freq 2, velocity 100 -> voice 0 HELD, gate=0001, env_reset[0] pulses once, ready returns 6 cycles after acceptance.
REQ-035 Note-ons 60, 62, 64, 65, then note-off 62 -> gate=1101; voice_done[1] -> voice 1 FREE; a new note-on 67 lands on voice 1.
REQ-036 Note-on 60 while voice 0 already holds 60 -> voice 0 retriggered, env_reset[0] pulse, no new voice used.
REQ-037 With VOICE_STEAL_EN: 4 voices HELD in the order 60, 62, 64, 65; note-on 67 -> voice 0 stolen. Without VOICE_STEAL_EN: event dropped, drop_count=1.
REQ-038 voice_done[2] pulsed during SCAN -> voice 2 FREE on the cycle after return to IDLE; 300 drops -> drop_count=255.

Source files
------------

// File: rtl/voice_pkg.sv
// ============================================================================
// voice_pkg
// Shared types and constants for the polyphonic voice allocator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package voice_pkg;

  // Life cycle of one oscillator voice
  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_state_t;

  // Allocator control states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } alloc_state_t;

  // Widest frequency / velocity words a note event can carry
  localparam int EV_FREQ_W = 32;
  localparam int EV_VEL_W  = 16;

  typedef struct packed {
    logic                 on;
    logic [6:0]           note;
    logic [EV_FREQ_W-1:0] freq;
    logic [EV_VEL_W-1:0]  velocity;
  } note_event_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/voice_slot.sv
// ============================================================================
// voice_slot
// Per-voice register file: state, note, age, frequency, velocity and the
// pending release-complete bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_slot
  import voice_pkg::*;
#(
  parameter int FREQ_W = 16,
  parameter int VEL_W  = 8,
  parameter int AGE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic              done,
  input  logic [6:0]        load_note,
  input  logic [FREQ_W-1:0] load_freq,
  input  logic [VEL_W-1:0]  load_velocity,
  output voice_state_t      state,
  output logic [6:0]        note,
  output logic [AGE_W-1:0]  age,
  output logic [FREQ_W-1:0] freq,
  output logic [VEL_W-1:0]  velocity,
  output logic              gate,
  output logic              env_reset
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic pending;

  // Voice registers: load on note-on, release on note-off, retire on done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= V_FREE;
      note      <= '0;
      age       <= '0;
      freq      <= '0;
      velocity  <= '0;
      pending   <= 1'b0;
      env_reset <= 1'b0;
    end else begin
      env_reset <= load;
      if (load) begin
        // Retrigger or steal: any latched release-complete is now stale
        state    <= V_HELD;
        note     <= load_note;
        freq     <= load_freq;
        velocity <= load_velocity;
        age      <= '0;
        pending  <= 1'b0;
      end else begin
        if (rel && state == V_HELD) begin
          state <= V_RELEASING;
        end
        if (age_inc && state != V_FREE && age != AGE_MAX) begin
          age <= age + 1'b1;
        end
        if (idle) begin
          if ((done || pending) && state == V_RELEASING) begin
            state <= V_FREE;
          end
          pending <= 1'b0;
        end else if (done && state == V_RELEASING) begin
          // Defer retirement so the voice set stays stable during a scan
          pending <= 1'b1;
        end
      end
    end
  end

  assign gate = (state == V_HELD);

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// voice_allocator
// Assigns note-on/note-off events to N_VOICES oscillator voices with a
// sequential one-voice-per-cycle scan. Optional voice stealing is enabled
// by defining VOICE_STEAL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_allocator
  import voice_pkg::*;
#(
  parameter int N_VOICES = 8,
  parameter int FREQ_W   = 16,
  parameter int VEL_W    = 8,
  parameter int AGE_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [6:0]                   ev_note,
  input  logic [FREQ_W-1:0]            ev_freq,
  input  logic [VEL_W-1:0]             ev_velocity,
  input  logic [N_VOICES-1:0]          voice_done,
  output logic [N_VOICES-1:0]          voice_gate,
  output logic [N_VOICES*FREQ_W-1:0]   voice_freq,
  output logic [N_VOICES*VEL_W-1:0]    voice_velocity,
  output logic [N_VOICES-1:0]          env_reset,
  output logic [7:0]                   drop_count
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

  alloc_state_t state, next_state;
  logic accept, in_idle, in_commit, last_idx;

  // Captured event
  logic              ev_on_q;
  logic [6:0]        ev_note_q;
  logic [FREQ_W-1:0] ev_freq_q;
  logic [VEL_W-1:0]  ev_vel_q;

  // Scan trackers
  logic [IDX_W-1:0] idx;
  logic             on_hit, off_hit, free_hit;
  logic [IDX_W-1:0] on_idx, off_idx, free_idx;
  logic             tgt_hit;
  logic [IDX_W-1:0] tgt_idx;
  logic             drop;

  // Per-voice views
  voice_state_t     v_state [N_VOICES];
  logic [6:0]       v_note  [N_VOICES];
  logic [AGE_W-1:0] v_age   [N_VOICES];
  logic [N_VOICES-1:0] load_vec, rel_vec, age_vec;

  voice_state_t cur_state;
  logic [6:0]   cur_note;

  assign cur_state = v_state[idx];
  assign cur_note  = v_note[idx];
  assign last_idx  = (idx == LAST_IDX);
  assign in_idle   = (state == S_IDLE);
  assign in_commit = (state == S_COMMIT);

`ifdef VOICE_STEAL_EN
  logic             rel_hit, held_hit;
  logic [IDX_W-1:0] rel_idx, held_idx;
  logic [AGE_W-1:0] rel_age, held_age, cur_age;
  assign cur_age = v_age[idx];
`else
  logic [N_VOICES-1:0] unused_age;
`endif

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake decode
  always_comb begin
    next_state = state;
    ev_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          accept     = 1'b1;
          next_state = S_SCAN;
        end
      end
      S_SCAN:   if (last_idx) next_state = S_COMMIT;
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Event capture and one-voice-per-cycle candidate tracking
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      idx      <= '0;
      on_hit   <= 1'b0;
      off_hit  <= 1'b0;
      free_hit <= 1'b0;
      on_idx   <= '0;
      off_idx  <= '0;
      free_idx <= '0;
`ifdef VOICE_STEAL_EN
      rel_hit  <= 1'b0;
      held_hit <= 1'b0;
      rel_idx  <= '0;
      held_idx <= '0;
      rel_age  <= '0;
      held_age <= '0;
`endif
    end else if (state == S_SCAN) begin
      idx <= idx + 1'b1;
      if (!on_hit && cur_state != V_FREE && cur_note == ev_note_q) begin
        on_hit <= 1'b1;
        on_idx <= idx;
      end
      if (!off_hit && cur_state == V_HELD && cur_note == ev_note_q) begin
        off_hit <= 1'b1;
        off_idx <= idx;
      end
      if (!free_hit && cur_state == V_FREE) begin
        free_hit <= 1'b1;
        free_idx <= idx;
      end
`ifdef VOICE_STEAL_EN
      // Strictly-greater comparison keeps the lowest index on age ties
      if (cur_state == V_RELEASING && (!rel_hit || cur_age > rel_age)) begin
        rel_hit <= 1'b1;
        rel_idx <= idx;
        rel_age <= cur_age;
      end
      if (cur_state == V_HELD && (!held_hit || cur_age > held_age)) begin
        held_hit <= 1'b1;
        held_idx <= idx;
        held_age <= cur_age;
      end
`endif
    end
  end

  // Event register loads only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_freq_q <= '0;
      ev_vel_q  <= '0;
    end else if (accept) begin
      ev_on_q   <= ev_on;
      ev_note_q <= ev_note;
      ev_freq_q <= ev_freq;
      ev_vel_q  <= ev_velocity;
    end
  end

  // Note-on target selection: retrigger, then free voice, then steal
  always_comb begin
    tgt_hit = 1'b0;
    tgt_idx = '0;
    if (on_hit) begin
      tgt_hit = 1'b1;
      tgt_idx = on_idx;
    end else if (free_hit) begin
      tgt_hit = 1'b1;
      tgt_idx = free_idx;
    end
`ifdef VOICE_STEAL_EN
    else if (rel_hit) begin
      tgt_hit = 1'b1;
      tgt_idx = rel_idx;
    end else if (held_hit) begin
      tgt_hit = 1'b1;
      tgt_idx = held_idx;
    end
`endif
  end

  assign drop = in_commit && ev_on_q && !tgt_hit;

  // Saturating count of note-ons that found no voice
  always_ff @(posedge clk) begin
    if (rst)                                     drop_count <= '0;
    else if (drop && drop_count != DROP_CNT_MAX) drop_count <= drop_count + 1'b1;
  end

  for (genvar i = 0; i < N_VOICES; i++) begin : g_slot
    assign load_vec[i] = in_commit && ev_on_q && tgt_hit && (tgt_idx == IDX_W'(i));
    assign age_vec[i]  = in_commit && ev_on_q && tgt_hit && (tgt_idx != IDX_W'(i));
    assign rel_vec[i]  = in_commit && !ev_on_q && off_hit && (off_idx == IDX_W'(i));

    voice_slot #(
      .FREQ_W(FREQ_W),
      .VEL_W (VEL_W),
      .AGE_W (AGE_W)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .idle         (in_idle),
      .load         (load_vec[i]),
      .rel          (rel_vec[i]),
      .age_inc      (age_vec[i]),
      .done         (voice_done[i]),
      .load_note    (ev_note_q),
      .load_freq    (ev_freq_q),
      .load_velocity(ev_vel_q),
      .state        (v_state[i]),
      .note         (v_note[i]),
      .age          (v_age[i]),
      .freq         (voice_freq[i*FREQ_W +: FREQ_W]),
      .velocity     (voice_velocity[i*VEL_W +: VEL_W]),
      .gate         (voice_gate[i]),
      .env_reset    (env_reset[i])
    );

`ifndef VOICE_STEAL_EN
    assign unused_age[i] = ^v_age[i];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// tb_voice_allocator
// Directed self-checking bench for voice_allocator with four voices.
// Expectations follow VOICE_STEAL_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_allocator;
  import voice_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [15:0] ev_freq = '0;
  logic [7:0]  ev_velocity = '0;
  logic [3:0]  voice_done = '0;
  logic [3:0]  voice_gate;
  logic [63:0] voice_freq;
  logic [31:0] voice_velocity;
  logic [3:0]  env_reset;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  int env_cnt [4];
  int lat;
  logic [1:0] st_rdy, st_next;

  voice_allocator #(
    .N_VOICES(4), .FREQ_W(16), .VEL_W(8), .AGE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq),
    .ev_velocity(ev_velocity), .voice_done(voice_done),
    .voice_gate(voice_gate), .voice_freq(voice_freq),
    .voice_velocity(voice_velocity), .env_reset(env_reset),
    .drop_count(drop_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int env_total();
    return env_cnt[0] + env_cnt[1] + env_cnt[2] + env_cnt[3];
  endfunction

  // Issue one event from a negedge; optionally pulse voice_done in the first SCAN cycle
  task automatic send(input note_event_t e, input logic [3:0] done_scan);
    int w;
    for (int i = 0; i < 4; i++) env_cnt[i] = 0;
    w = 0;
    while (!ev_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    ev_valid = 1'b1;
    ev_on = e.on;
    ev_note = e.note;
    ev_freq = e.freq[15:0];
    ev_velocity = e.velocity[7:0];
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      ev_valid = 1'b0;
      lat++;
      voice_done = (lat == 1) ? done_scan : 4'b0000;
      for (int i = 0; i < 4; i++) env_cnt[i] += int'(env_reset[i]);
    end while (!ev_ready && lat < 40);
    check("ready_returns", ev_ready, 1'b1);
    st_rdy = dut.v_state[2];
    @(negedge clk);
    st_next = dut.v_state[2];
    for (int i = 0; i < 4; i++) env_cnt[i] += int'(env_reset[i]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) env_cnt[i] += int'(env_reset[i]);
  endtask

  task automatic on_ev(input logic [6:0] n, input logic [15:0] f, input logic [7:0] v);
    send('{on: 1'b1, note: n, freq: 32'(f), velocity: 16'(v)}, 4'b0000);
  endtask

  task automatic off_ev(input logic [6:0] n);
    send('{on: 1'b0, note: n, freq: 32'd0, velocity: 16'd0}, 4'b0000);
  endtask

  task automatic pulse_done(input logic [3:0] m);
    voice_done = m;
    @(negedge clk);
    voice_done = 4'b0000;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ev_ready, 1'b1);
    check("rst_gate", voice_gate, 4'b0000);
    check("rst_env", env_reset, 4'b0000);
    check("rst_drop", drop_count, 8'd0);

    // First note-on: latency and single envelope restart
    on_ev(7'd60, 16'd2, 8'd100);
    check("first_latency", lat, 6);
    check("first_env0", env_cnt[0], 1);
    check("first_env_total", env_total(), 1);
    check("first_gate", voice_gate, 4'b0001);
    check("first_freq0", voice_freq[15:0], 16'd2);
    check("first_vel0", voice_velocity[7:0], 8'd100);

    // Fill, release, retire, reuse
    on_ev(7'd62, 16'd620, 8'd62);
    on_ev(7'd64, 16'd640, 8'd64);
    on_ev(7'd65, 16'd650, 8'd65);
    check("fill_gate", voice_gate, 4'b1111);
    off_ev(7'd62);
    check("off_gate", voice_gate, 4'b1101);
    check("off_freq1_held", voice_freq[31:16], 16'd620);
    pulse_done(4'b0010);
    check("done_v1_free", dut.v_state[1], V_FREE);
    on_ev(7'd67, 16'd670, 8'd67);
    check("reuse_env1", env_cnt[1], 1);
    check("reuse_gate", voice_gate, 4'b1111);
    check("reuse_freq1", voice_freq[31:16], 16'd670);

    // Retrigger of a held note
    on_ev(7'd60, 16'd600, 8'd77);
    check("retrig_env0", env_cnt[0], 1);
    check("retrig_env_total", env_total(), 1);
    check("retrig_vel0", voice_velocity[7:0], 8'd77);
    pulse_done(4'b0001);
    check("done_held_ignored", voice_gate, 4'b1111);

    // All voices held, one more note-on
    do_reset();
    on_ev(7'd60, 16'd600, 8'd60);
    on_ev(7'd62, 16'd620, 8'd62);
    on_ev(7'd64, 16'd640, 8'd64);
    on_ev(7'd65, 16'd650, 8'd65);
    on_ev(7'd67, 16'd670, 8'd67);
`ifdef VOICE_STEAL_EN
    check("steal_drop", drop_count, 8'd0);
    check("steal_env0", env_cnt[0], 1);
    check("steal_freq0", voice_freq[15:0], 16'd670);
`else
    check("full_drop", drop_count, 8'd1);
    check("full_env_total", env_total(), 0);
    check("full_freq0", voice_freq[15:0], 16'd600);
`endif
    check("full_gate", voice_gate, 4'b1111);

    // Release-complete arriving mid-scan is deferred to IDLE
    off_ev(7'd65);
    check("off65_gate", voice_gate, 4'b0111);
    pulse_done(4'b1000);
    off_ev(7'd64);
    check("off64_gate", voice_gate, 4'b0011);
    send('{on: 1'b1, note: 7'd62, freq: 32'd621, velocity: 16'd62}, 4'b0100);
    check("pend_v2_at_idle", st_rdy, V_RELEASING);
    check("pend_v2_after", st_next, V_FREE);
    check("pend_retrig_env1", env_cnt[1], 1);
    on_ev(7'd70, 16'd700, 8'd70);
    check("pend_reuse_env2", env_cnt[2], 1);
    check("pend_reuse_gate", voice_gate, 4'b0111);
    check("pend_reuse_freq2", voice_freq[47:32], 16'd700);

    // Drop counter saturation
    on_ev(7'd72, 16'd720, 8'd72);
    check("sat_fill_gate", voice_gate, 4'b1111);
    for (int k = 0; k < 253; k++) on_ev(7'd80, 16'd800, 8'd80);
`ifdef VOICE_STEAL_EN
    check("drop_254", drop_count, 8'd0);
`else
    check("drop_254", drop_count, 8'd254);
`endif
    for (int k = 0; k < 47; k++) on_ev(7'd80, 16'd800, 8'd80);
`ifdef VOICE_STEAL_EN
    check("drop_sat", drop_count, 8'd0);
`else
    check("drop_sat", drop_count, 8'd255);
`endif

    // Reset in the middle of a scan aborts the event
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_note = 7'd90;
    ev_freq = 16'd900;
    ev_velocity = 8'd90;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    check("midscan_busy", ev_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", ev_ready, 1'b1);
    check("midrst_gate", voice_gate, 4'b0000);
    check("midrst_drop", drop_count, 8'd0);
    check("midrst_freq", voice_freq, 64'd0);
    repeat (8) @(negedge clk);
    check("midrst_no_commit", voice_gate, 4'b0000);
    check("midrst_no_env", env_reset, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
